// File: rtl/rat_step_ctrl.sv
// Single-step move controller for the maze rat: checks the maze edge, then the
// wall memory, and either loads the new position or reports a rejected move.
module rat_step_ctrl #(
  parameter int MAX_IDX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dir,
  input  logic [3:0] curRow,
  input  logic [3:0] curCol,
  output logic       memRd,
  output logic [7:0] memAddr,
  input  logic       memData,
  output logic [3:0] nextRow,
  output logic [3:0] nextCol,
  output logic       ldRow,
  output logic       ldCol,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_FAIL  = 3'd4;

  localparam logic [3:0] MAX_V = 4'(MAX_IDX);

  logic [2:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] next_row_q, next_row_d;
  logic [3:0] next_col_q, next_col_d;

  logic [3:0] cand_row;
  logic [3:0] cand_col;
  logic       boundary;
  logic       rd_now;

  // Candidate comes only from the captured move; ">=" keeps an out-of-range
  // start position from ever wrapping past the maze edge.
  always_comb begin
    cand_row = row_q;
    cand_col = col_q;
    boundary = 1'b0;
    case (dir_q)
      2'b00: begin
        if (row_q == 4'd0) boundary = 1'b1;
        else               cand_row = row_q - 4'd1;
      end
      2'b01: begin
        if (col_q >= MAX_V) boundary = 1'b1;
        else                cand_col = col_q + 4'd1;
      end
      2'b10: begin
        if (col_q == 4'd0) boundary = 1'b1;
        else               cand_col = col_q - 4'd1;
      end
      default: begin
        if (row_q >= MAX_V) boundary = 1'b1;
        else                cand_row = row_q + 4'd1;
      end
    endcase
  end

  assign rd_now = (state_q == S_CHECK) && !boundary;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    next_row_d = next_row_q;
    next_col_d = next_col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          row_d   = curRow;
          col_d   = curCol;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (boundary) begin
          state_d = S_FAIL;
        end else begin
          addr_d  = {cand_row, cand_col};
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memData) begin
          state_d = S_FAIL;
        end else begin
          next_row_d = cand_row;
          next_col_d = cand_col;
          state_d    = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      dir_q      <= 2'b00;
      row_q      <= 4'd0;
      col_q      <= 4'd0;
      addr_q     <= 8'd0;
      next_row_q <= 4'd0;
      next_col_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      next_row_q <= next_row_d;
      next_col_q <= next_col_d;
    end
  end

  // Vertical moves (00/11) have equal direction bits and load only the row.
  assign memRd   = rd_now;
  assign memAddr = rd_now ? {cand_row, cand_col} : addr_q;
  assign nextRow = next_row_q;
  assign nextCol = next_col_q;
  assign ldRow   = (state_q == S_LOAD) && (dir_q[1] == dir_q[0]);
  assign ldCol   = (state_q == S_LOAD) && (dir_q[1] != dir_q[0]);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_LOAD);
  assign fail    = (state_q == S_FAIL);

endmodule

// File: tb/tb_rat_step_ctrl.sv
// Scoreboard bench for rat_step_ctrl: two instances (MAX_IDX 15 and 9) driven
// with hand-computed move vectors; a negedge monitor checks every strobe.
module tb_rat_step_ctrl;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [1:0] dir;
  logic [3:0] cur_row, cur_col;
  logic       mem_data;

  logic       mem_rd_a, ld_row_a, ld_col_a, busy_a, done_a, fail_a;
  logic [7:0] mem_addr_a;
  logic [3:0] next_row_a, next_col_a;
  logic       mem_rd_b, ld_row_b, ld_col_b, busy_b, done_b, fail_b;
  logic [7:0] mem_addr_b;
  logic [3:0] next_row_b, next_col_b;

  typedef struct {
    int         id;
    logic [7:0] addr;
    int         cyc;
  } rd_exp_t;

  typedef struct {
    int         id;
    logic       is_done;
    logic       ldr;
    logic       ldc;
    logic [3:0] nr;
    logic [3:0] nc;
    int         cyc;
  } res_exp_t;

  rd_exp_t  rd_q[$];
  res_exp_t res_q[$];

  int cyc;
  int checks;
  int errors;

  rat_step_ctrl #(.MAX_IDX(15)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dir(dir),
    .curRow(cur_row), .curCol(cur_col),
    .memRd(mem_rd_a), .memAddr(mem_addr_a), .memData(mem_data),
    .nextRow(next_row_a), .nextCol(next_col_a),
    .ldRow(ld_row_a), .ldCol(ld_col_a),
    .busy(busy_a), .done(done_a), .fail(fail_a)
  );

  rat_step_ctrl #(.MAX_IDX(9)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dir(dir),
    .curRow(cur_row), .curCol(cur_col),
    .memRd(mem_rd_b), .memAddr(mem_addr_b), .memData(mem_data),
    .nextRow(next_row_b), .nextCol(next_col_b),
    .ldRow(ld_row_b), .ldCol(ld_col_b),
    .busy(busy_b), .done(done_b), .fail(fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic process_events(input int id, input logic rd, input logic [7:0] addr,
                                input logic dn, input logic fl, input logic ldr,
                                input logic ldc, input logic [3:0] nr, input logic [3:0] nc);
    rd_exp_t  r;
    res_exp_t e;
    if (rd) begin
      if (rd_q.size() == 0) begin
        check_output($sformatf("unexpected_memRd_dut%0d", id), 32'(rd), 32'd0);
      end else begin
        r = rd_q.pop_front();
        check_output("memRd_dut", 32'(id), 32'(r.id));
        check_output("memAddr", 32'(addr), 32'(r.addr));
        check_output("memRd_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
    if ((ldr || ldc) && !dn) begin
      check_output($sformatf("ld_without_done_dut%0d", id), {30'd0, ldr, ldc}, 32'd0);
    end
    if (dn || fl) begin
      check_output("done_fail_exclusive", 32'(dn && fl), 32'd0);
      if (res_q.size() == 0) begin
        check_output($sformatf("unexpected_result_dut%0d", id), {30'd0, dn, fl}, 32'd0);
      end else begin
        e = res_q.pop_front();
        check_output("result_dut", 32'(id), 32'(e.id));
        check_output("done", 32'(dn), 32'(e.is_done));
        check_output("fail", 32'(fl), 32'(!e.is_done));
        check_output("ldRow", 32'(ldr), 32'(e.ldr));
        check_output("ldCol", 32'(ldc), 32'(e.ldc));
        check_output("nextRow", 32'(nr), 32'(e.nr));
        check_output("nextCol", 32'(nc), 32'(e.nc));
        check_output("result_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  // Monitor: cycle k after the start-sampling edge is observed with cyc = c0 + k - 1.
  always @(negedge clk) begin
    process_events(0, mem_rd_a, mem_addr_a, done_a, fail_a, ld_row_a, ld_col_a, next_row_a, next_col_a);
    process_events(1, mem_rd_b, mem_addr_b, done_b, fail_b, ld_row_b, ld_col_b, next_row_b, next_col_b);
  end

  task automatic set_start(input int id, input logic v);
    if (id == 0) start_a = v;
    else         start_b = v;
  endtask

  function automatic logic get_busy(input int id);
    return (id == 0) ? busy_a : busy_b;
  endfunction

  task automatic check_quiet(input int id, input string tag);
    if (id == 0) begin
      check_output({tag, "_a_outputs"},
                   {mem_rd_a, mem_addr_a, next_row_a, next_col_a, ld_row_a, ld_col_a, busy_a, done_a, fail_a}, 32'd0);
    end else begin
      check_output({tag, "_b_outputs"},
                   {mem_rd_b, mem_addr_b, next_row_b, next_col_b, ld_row_b, ld_col_b, busy_b, done_b, fail_b}, 32'd0);
    end
  endtask

  // Entered right after the start-sampling edge (cycle 1 is the next negedge).
  task automatic wait_idle(input int id, input int lat);
    int k;
    k = 0;
    while (k < 3) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        dir     = 2'($urandom);
        cur_row = 4'($urandom);
        cur_col = 4'($urandom);
      end
      if (k == 2) set_start(id, 1'b1);
      if (k == 3) set_start(id, 1'b0);
    end
    while (get_busy(id) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check_output($sformatf("idle_cycle_dut%0d", id), 32'(k), 32'(lat + 1));
  endtask

  task automatic push_expect(input int id, input int c0, input logic has_rd, input logic [7:0] addr,
                             input logic is_done, input logic [3:0] nr, input logic [3:0] nc,
                             input logic ldr, input logic ldc, input int lat);
    if (has_rd) rd_q.push_back('{id: id, addr: addr, cyc: c0});
    res_q.push_back('{id: id, is_done: is_done, ldr: ldr, ldc: ldc, nr: nr, nc: nc, cyc: c0 + lat - 1});
  endtask

  task automatic apply_stimulus(input int id, input logic [1:0] d, input logic [3:0] r, input logic [3:0] c,
                                input logic wall, input logic has_rd, input logic [7:0] addr,
                                input logic is_done, input logic [3:0] nr, input logic [3:0] nc,
                                input logic ldr, input logic ldc, input int lat);
    int c0;
    @(negedge clk);
    dir      = d;
    cur_row  = r;
    cur_col  = c;
    mem_data = wall;
    set_start(id, 1'b1);
    @(posedge clk);
    #1;
    c0 = cyc;
    push_expect(id, c0, has_rd, addr, is_done, nr, nc, ldr, ldc, lat);
    set_start(id, 1'b0);
    check_output($sformatf("busy_after_start_dut%0d", id), 32'(get_busy(id)), 32'd1);
    wait_idle(id, lat);
  endtask

  // Reset lands in WAIT with start still high; the aborted move must emit
  // nothing, and release must start a new move from freshly captured inputs.
  task automatic abort_test();
    int c0;
    @(negedge clk);
    dir      = 2'b01;
    cur_row  = 4'd6;
    cur_col  = 4'd6;
    mem_data = 1'b0;
    start_a  = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    rd_q.push_back('{id: 0, addr: 8'h67, cyc: c0});
    @(negedge clk);
    @(negedge clk);
    dir     = 2'b11;
    cur_row = 4'd1;
    cur_col = 4'd1;
    #2;
    rst = 1'b0;
    #1;
    check_quiet(0, "abort_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    push_expect(0, c0, 1'b1, 8'h21, 1'b1, 4'd2, 4'd1, 1'b1, 1'b0, 3);
    start_a = 1'b0;
    check_output("busy_after_release", 32'(busy_a), 32'd1);
    wait_idle(0, 3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    dir      = 2'b00;
    cur_row  = 4'd0;
    cur_col  = 4'd0;
    mem_data = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_quiet(0, "reset");
    check_quiet(1, "reset");
    @(negedge clk);
    rst = 1'b1;

    // id, dir, row, col, wall, has_rd, addr, done, nextRow, nextCol, ldRow, ldCol, latency
    apply_stimulus(0, 2'b01, 4'd3,  4'd4,  1'b0, 1'b1, 8'h35, 1'b1, 4'd3,  4'd5,  1'b0, 1'b1, 3);
    apply_stimulus(0, 2'b00, 4'd0,  4'd7,  1'b0, 1'b0, 8'h00, 1'b0, 4'd3,  4'd5,  1'b0, 1'b0, 2);
    apply_stimulus(0, 2'b11, 4'd15, 4'd15, 1'b0, 1'b0, 8'h00, 1'b0, 4'd3,  4'd5,  1'b0, 1'b0, 2);
    apply_stimulus(0, 2'b11, 4'd5,  4'd5,  1'b1, 1'b1, 8'h65, 1'b0, 4'd3,  4'd5,  1'b0, 1'b0, 3);
    apply_stimulus(0, 2'b10, 4'd5,  4'd5,  1'b0, 1'b1, 8'h54, 1'b1, 4'd5,  4'd4,  1'b0, 1'b1, 3);
    apply_stimulus(0, 2'b00, 4'd5,  4'd5,  1'b0, 1'b1, 8'h45, 1'b1, 4'd4,  4'd5,  1'b1, 1'b0, 3);
    apply_stimulus(0, 2'b01, 4'd2,  4'd15, 1'b0, 1'b0, 8'h00, 1'b0, 4'd4,  4'd5,  1'b0, 1'b0, 2);
    apply_stimulus(0, 2'b10, 4'd2,  4'd0,  1'b0, 1'b0, 8'h00, 1'b0, 4'd4,  4'd5,  1'b0, 1'b0, 2);
    apply_stimulus(0, 2'b11, 4'd14, 4'd15, 1'b0, 1'b1, 8'hFF, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 3);

    apply_stimulus(1, 2'b11, 4'd9,  4'd2,  1'b0, 1'b0, 8'h00, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 2);
    apply_stimulus(1, 2'b11, 4'd8,  4'd2,  1'b0, 1'b1, 8'h92, 1'b1, 4'd9,  4'd2,  1'b1, 1'b0, 3);
    apply_stimulus(1, 2'b01, 4'd4,  4'd9,  1'b0, 1'b0, 8'h00, 1'b0, 4'd9,  4'd2,  1'b0, 1'b0, 2);
    apply_stimulus(1, 2'b01, 4'd4,  4'd8,  1'b0, 1'b1, 8'h49, 1'b1, 4'd4,  4'd9,  1'b0, 1'b1, 3);

    abort_test();

    repeat (4) @(negedge clk);
    check_output("leftover_memRd_expectations", 32'(rd_q.size()), 32'd0);
    check_output("leftover_result_expectations", 32'(res_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
